conv_window_feeder: RTL and testbench
=====================================

# conv_window_feeder

Sequencer that drives a `pe` processing element from the initiator side of its `inmap`/`weight`/`bias` interface. It holds one input feature map and one K×K kernel, walks every valid convolution window, streams each window's K·K (pixel, weight) pairs into the PE and collects one `outmap` result per window. It sits between the layer controller/loader and a single PE instance; `K*K` must equal the PE's `PERIOD`.

## Interface
- `IMG_W`, default 8: feature-map width in pixels.
- `IMG_H`, default 8: feature-map height in pixels.
- `K`, default 5: kernel side; products per window `K*K` = 25 = PE `PERIOD`.
- `DATA_SIZE`, default 8: signed Q4.3 sample width.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_en` in 1: load strobe for image/kernel storage.
- `ld_sel` in 1: 0 = image word, 1 = kernel word.
- `ld_addr` in `$clog2(IMG_W*IMG_H)`: row-major address; kernel uses the low bits, 0..K*K-1.
- `ld_data` in `DATA_SIZE`: signed sample to store.
- `bias_in` in `DATA_SIZE`: bias, sampled at `start`.
- `start` in 1: begin a full-map pass.
- `busy` out 1: pass in progress.
- `done` out 1: one-cycle pulse at the end of the pass.
- `inmap`, `weight` out `DATA_SIZE` each: signed to PE.
- `inmap_vld`, `weight_vld` out 1 each: to PE; always equal.
- `bias` out `DATA_SIZE`: to PE; held for the whole pass.
- `outmap` in `DATA_SIZE`: signed result from PE.
- `outmap_vld` in 1: PE result valid.
- `res_data` out `DATA_SIZE`: captured window result.
- `res_row`, `res_col` out `$clog2(IMG_H)`, `$clog2(IMG_W)`: window origin.
- `res_vld` out 1: one-cycle result strobe.

## Operation
- Output map is (IMG_H−K+1)×(IMG_W−K+1), 4×4 = 16 windows by default, visited row-major (col fastest).
- Per window, pairs are issued row-major over the kernel: step i = ky*K+kx sends `inmap` = img[row+ky][col+kx] and `weight` = ker[i].
- FSM states:
  - IDLE: `start` → STREAM at window (0,0), latch `bias_in`.
  - STREAM: issue one pair per cycle for K*K cycles, then → WAIT.
  - WAIT: `outmap_vld` → capture result. If this was the last window → IDLE with `done`; otherwise → STREAM at the next window.
- `start` while busy is ignored. `ld_en` while busy is ignored, so storage is stable during a pass. Loads in IDLE take effect next cycle.
- `outmap_vld` outside WAIT is ignored and does not count as a result.
- No arithmetic is performed here. Data passes through unmodified as signed two's complement. Index counters wrap only via their window-end compares, never by overflow.

## Timing
- Reset values: `busy`, `done`, `res_vld`, `inmap_vld`, `weight_vld` = 0; `inmap`, `weight`, `bias`, `res_data`, `res_row`, `res_col` = 0; FSM in IDLE; storage contents are undefined.
- `start` sampled high at edge t → first pair is valid in cycle t+1. `busy` = 1 from t+1.
- The stream is contiguous. Valids are high for exactly K*K consecutive cycles and drop the cycle after the last pair.
- `outmap_vld` sampled in WAIT at edge w → `res_vld`, `res_data`, `res_row`, `res_col` are valid in cycle w+1. The next window's first pair is also valid in w+1.
- Last window: `done` and the final `res_vld` are asserted in the same cycle. `busy` is 0 in that cycle.
- WAIT has no timeout; it waits indefinitely.
- `rst` mid-pass: next cycle returns to IDLE with every output at its reset value. A late `outmap_vld` is then ignored.

## Structure
- Shared package `conv_pkg`: `DATA_SIZE`, `HALFWORD_WIDTH` (16), the FSM state enum, and Q-format constant `FRAC_BITS` = 3.
- Sub-module `window_addr_gen`: counters for (row, col, ky, kx), the flat image address and kernel index, and `last_pair`/`last_window` flags.
- Image and kernel storage are register arrays in the top level.

## Test plan
- Load img[r][c]=r*8+c and ker[i]=i; start → window (0,0) streams `inmap` 0,1,2,3,4,8,…,36 with `weight` 0..24. Valids are high for exactly 25 cycles.
- Behavioral PE (`outmap_vld` 3 cycles after the last pair, `outmap` = window index) → 16 `res_vld` strobes with `res_data` 0..15. (`res_row`,`res_col`) go (0,0)…(3,3). `done` coincides with the 16th strobe.
- Pulse `outmap_vld` during STREAM, and `start`/`ld_en` during a pass → no extra `res_vld`, no restart, storage unchanged.
- `bias_in`=8'h09 at start, then changed to 8'h01 mid-pass → `bias` holds 8'h09 until `done`.
- Assert `rst` while in WAIT at window 5 → next cycle all outputs are 0 and the FSM is in IDLE. A later `outmap_vld` produces nothing. A new `start` restarts at (0,0).
- Signed pass-through: ker[0]=8'h83, img[0][0]=8'hFF → first pair shows −125 and −1 (Q4.3: −15.625, −0.125).

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution window feeder: sample format and
// sequencer states.
package conv_pkg;
  localparam int DATA_SIZE      = 8;
  localparam int HALFWORD_WIDTH = 16;
  localparam int FRAC_BITS      = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2
  } state_t;
endpackage

// File: rtl/conv_window_feeder_window_addr_gen.sv
// Window walker: (row, col, ky, kx) always name the pair on the PE port.
// The read addresses are taken from the next-state counters so the output
// registers capture the pair that becomes current at the same edge.
module window_addr_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int K     = 5,
  parameter int RW    = $clog2(IMG_H),
  parameter int CW    = $clog2(IMG_W),
  parameter int KCW   = $clog2(K),
  parameter int AW    = $clog2(IMG_W*IMG_H),
  parameter int KW    = $clog2(K*K)
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step_pair,
  input  logic          step_win,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic [AW-1:0] img_addr,
  output logic [KW-1:0] ker_idx,
  output logic          last_pair,
  output logic          last_window
);
  logic [KCW-1:0] ky, kx, ky_n, kx_n;
  logic [RW-1:0]  row_n;
  logic [CW-1:0]  col_n;

  always_comb begin
    row_n = row;
    col_n = col;
    ky_n  = ky;
    kx_n  = kx;
    if (clear) begin
      row_n = '0;
      col_n = '0;
      ky_n  = '0;
      kx_n  = '0;
    end else if (step_pair) begin
      if (kx == KCW'(K-1)) begin
        kx_n = '0;
        ky_n = ky + KCW'(1);
      end else begin
        kx_n = kx + KCW'(1);
      end
    end else if (step_win) begin
      ky_n = '0;
      kx_n = '0;
      if (col == CW'(IMG_W-K)) begin
        col_n = '0;
        row_n = row + RW'(1);
      end else begin
        col_n = col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
      ky  <= '0;
      kx  <= '0;
    end else begin
      row <= row_n;
      col <= col_n;
      ky  <= ky_n;
      kx  <= kx_n;
    end
  end

  assign img_addr    = AW'((int'(row_n) + int'(ky_n)) * IMG_W + int'(col_n) + int'(kx_n));
  assign ker_idx     = KW'(int'(ky_n) * K + int'(kx_n));
  assign last_pair   = (ky == KCW'(K-1)) && (kx == KCW'(K-1));
  assign last_window = (row == RW'(IMG_H-K)) && (col == CW'(IMG_W-K));
endmodule

// File: rtl/conv_window_feeder.sv
// Streams every K x K window of a stored feature map, paired with the
// stored kernel, into one PE and collects one result per window.
module conv_window_feeder #(
  parameter int IMG_W     = 8,
  parameter int IMG_H     = 8,
  parameter int K         = 5,
  parameter int DATA_SIZE = 8
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_en,
  input  logic                          ld_sel,
  input  logic [$clog2(IMG_W*IMG_H)-1:0] ld_addr,
  input  logic [DATA_SIZE-1:0]          ld_data,
  input  logic [DATA_SIZE-1:0]          bias_in,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_SIZE-1:0]          inmap,
  output logic [DATA_SIZE-1:0]          weight,
  output logic                          inmap_vld,
  output logic                          weight_vld,
  output logic [DATA_SIZE-1:0]          bias,
  input  logic [DATA_SIZE-1:0]          outmap,
  input  logic                          outmap_vld,
  output logic [DATA_SIZE-1:0]          res_data,
  output logic [$clog2(IMG_H)-1:0]      res_row,
  output logic [$clog2(IMG_W)-1:0]      res_col,
  output logic                          res_vld
);
  import conv_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NKER = K * K;
  localparam int AW   = $clog2(NPIX);
  localparam int KW   = $clog2(NKER);
  localparam int RW   = $clog2(IMG_H);
  localparam int CW   = $clog2(IMG_W);

  logic [DATA_SIZE-1:0] img [NPIX];
  logic [DATA_SIZE-1:0] ker [NKER];

  state_t        state, state_nxt;
  logic          clear, step_pair, step_win, issue, capture, finish;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] img_addr;
  logic [KW-1:0] ker_idx;
  logic          last_pair, last_window;

  window_addr_gen #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K)
  ) u_addr (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .step_pair  (step_pair),
    .step_win   (step_win),
    .row        (row),
    .col        (col),
    .img_addr   (img_addr),
    .ker_idx    (ker_idx),
    .last_pair  (last_pair),
    .last_window(last_window)
  );

  // Storage only accepts writes while idle, so a pass sees a frozen map.
  always_ff @(posedge clk) begin
    if (ld_en && state == ST_IDLE) begin
      if (!ld_sel) begin
        if (int'(ld_addr) < NPIX) img[ld_addr] <= ld_data;
      end else if (int'(ld_addr) < NKER) begin
        ker[ld_addr[KW-1:0]] <= ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    step_pair = 1'b0;
    step_win  = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        state_nxt = ST_STREAM;
        clear     = 1'b1;
        issue     = 1'b1;
      end
      ST_STREAM: begin
        if (last_pair) begin
          state_nxt = ST_WAIT;
        end else begin
          step_pair = 1'b1;
          issue     = 1'b1;
        end
      end
      ST_WAIT: if (outmap_vld) begin
        capture = 1'b1;
        if (last_window) begin
          state_nxt = ST_IDLE;
          clear     = 1'b1;
          finish    = 1'b1;
        end else begin
          state_nxt = ST_STREAM;
          step_win  = 1'b1;
          issue     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      res_vld    <= 1'b0;
      inmap_vld  <= 1'b0;
      weight_vld <= 1'b0;
      inmap      <= '0;
      weight     <= '0;
      bias       <= '0;
      res_data   <= '0;
      res_row    <= '0;
      res_col    <= '0;
    end else begin
      done       <= finish;
      res_vld    <= capture;
      inmap_vld  <= issue;
      weight_vld <= issue;
      if (issue) begin
        inmap  <= img[img_addr];
        weight <= ker[ker_idx];
      end
      if (state == ST_IDLE && start) bias <= bias_in;
      if (capture) begin
        res_data <= outmap;
        res_row  <= row;
        res_col  <= col;
      end
    end
  end

  assign busy = (state != ST_IDLE);
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with an inline behavioral PE and a
// reference copy of the loaded image/kernel.
module tb_conv_window_feeder;
  localparam int IMG_W = 8, IMG_H = 8, K = 5, DS = 8;
  localparam int OW = IMG_W - K + 1, OH = IMG_H - K + 1;
  localparam int NWIN = OW * OH, NP = K * K;

  logic          clk = 1'b0;
  logic          rst, ld_en, ld_sel, start, outmap_vld;
  logic [5:0]    ld_addr;
  logic [DS-1:0] ld_data, bias_in, outmap;
  logic          busy, done, inmap_vld, weight_vld, res_vld;
  logic [DS-1:0] inmap, weight, bias, res_data;
  logic [2:0]    res_row, res_col;

  logic [DS-1:0] img_m [IMG_W*IMG_H];
  logic [DS-1:0] ker_m [NP];

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  conv_window_feeder #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DATA_SIZE(DS)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr),
    .ld_data(ld_data), .bias_in(bias_in), .start(start), .busy(busy), .done(done),
    .inmap(inmap), .weight(weight), .inmap_vld(inmap_vld), .weight_vld(weight_vld),
    .bias(bias), .outmap(outmap), .outmap_vld(outmap_vld), .res_data(res_data),
    .res_row(res_row), .res_col(res_col), .res_vld(res_vld)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_res_vld"}, res_vld, 0);
    check({pfx, "_inmap_vld"}, inmap_vld, 0);
    check({pfx, "_weight_vld"}, weight_vld, 0);
    check({pfx, "_inmap"}, inmap, 0);
    check({pfx, "_weight"}, weight, 0);
    check({pfx, "_bias"}, bias, 0);
    check({pfx, "_res_data"}, res_data, 0);
    check({pfx, "_res_row"}, res_row, 0);
    check({pfx, "_res_col"}, res_col, 0);
  endtask

  task automatic load(input bit sel, input int addr, input logic [DS-1:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 6'(addr); ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One full pass; rst_win >= 0 resets in WAIT of that window instead.
  task automatic run_pass(input int rst_win, input bit inject, input bit sgn);
    int w, p, run, cd, wdone, nres, cyc, r, c, ky, kx;
    bit exp_res, prev, fin;
    w = 0; p = 0; run = 0; cd = 0; wdone = 0; nres = 0; cyc = 0;
    exp_res = 0; prev = 0; fin = 0;
    bias_in = 8'h09; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bias_in = 8'h01;
    check("first_vld", inmap_vld, 1);
    check("busy_on", busy, 1);
    while (!fin) begin
      outmap_vld = 1'b0; start = 1'b0; ld_en = 1'b0;
      check("res_vld", res_vld, int'(exp_res));
      check("done", done, int'(exp_res && nres == NWIN-1));
      if (res_vld) begin
        check("res_data", res_data, nres);
        check("res_row", res_row, nres / OW);
        check("res_col", res_col, nres % OW);
        check("busy_at_res", busy, int'(nres != NWIN-1));
        nres++;
        if (nres == NWIN) fin = 1;
      end
      exp_res = 0;
      if (!fin) check("bias_hold", bias, 9);
      check("wvld_eq", weight_vld, inmap_vld);
      if (inmap_vld) begin
        r = w / OW; c = w % OW; ky = p / K; kx = p % K;
        check("inmap", inmap, img_m[(r+ky)*IMG_W + c + kx]);
        check("weight", weight, ker_m[p]);
        if (sgn && w == 0 && p == 0) begin
          check("sgn_inmap", int'($signed(inmap)), -1);
          check("sgn_weight", int'($signed(weight)), -125);
        end
        if (inject && w == 2 && p == 10) begin outmap_vld = 1'b1; outmap = 8'h55; end
        if (inject && w == 3 && p == 5) begin
          start = 1'b1; ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 6'd45; ld_data = 8'h77;
        end
        if (inject && w == 3 && p == 6) begin
          ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 6'd3; ld_data = 8'h66;
        end
        p++; run++;
      end else begin
        if (prev) begin
          check("run_len", run, NP);
          run = 0; p = 0; wdone = w; w++; cd = 3;
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            if (wdone == rst_win) begin
              rst = 1'b1;
              @(negedge clk);
              check_reset("midrst");
              rst = 1'b0; outmap_vld = 1'b1; outmap = 8'h42;
              @(negedge clk);
              outmap_vld = 1'b0;
              check("late_res_vld", res_vld, 0);
              check("late_busy", busy, 0);
              @(negedge clk);
              check("late_res_vld2", res_vld, 0);
              check("late_inmap_vld", inmap_vld, 0);
              return;
            end
            outmap_vld = 1'b1; outmap = DS'(wdone); exp_res = 1;
          end
        end
      end
      prev = inmap_vld;
      cyc++;
      if (cyc > 3000) begin
        check("timeout_results", nres, NWIN);
        fin = 1;
      end
      @(negedge clk);
    end
    outmap_vld = 1'b0;
    check("end_busy", busy, 0);
    check("end_vld", inmap_vld, 0);
    check("end_done", done, 0);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    bias_in = '0; start = 1'b0; outmap_vld = 1'b0; outmap = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < IMG_W*IMG_H; i++) begin
      img_m[i] = DS'(i);
      load(1'b0, i, DS'(i));
    end
    for (int i = 0; i < NP; i++) begin
      ker_m[i] = DS'(i);
      load(1'b1, i, DS'(i));
    end
    run_pass(-1, 1'b1, 1'b0);
    run_pass(5, 1'b0, 1'b0);
    run_pass(-1, 1'b0, 1'b0);
    ker_m[0] = 8'h83; load(1'b1, 0, 8'h83);
    img_m[0] = 8'hFF; load(1'b0, 0, 8'hFF);
    run_pass(-1, 1'b0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
